arb_rsp_router: RTL and testbench
=================================

// Module: arb_rsp_router
// PURPOSE
//  Sits downstream of the round-robin arbitration tree, between its arbitrated request output and the shared slave.
//  - On every accepted request, records the winning input index in an in-order ID FIFO.
//  - Routes each returning response back to the input port that issued the matching request.
//  - Back-pressures the arbiter when MaxOutstanding requests are in flight.
// PARAMETERS
//  NumIn           4   number of arbitrated input ports (>=1)
//  RspWidth        32  response payload width in bits
//  MaxOutstanding  8   ID FIFO depth = max requests in flight (>=1)
// PORTS
//  clk_i        in   1                 clock, all logic on rising edge
//  rst_i        in   1                 reset, asynchronous, active-high
//  flush_i      in   1                 synchronous clear of ID FIFO and counters
//  slv_req_i    in   1                 arbitrated request valid (arbiter req_o)
//  slv_idx_i    in   IdxWidth          winning input index (arbiter idx_o)
//  slv_gnt_o    out  1                 grant back to arbiter (arbiter gnt_i)
//  mst_req_o    out  1                 request towards shared slave
//  mst_gnt_i    in   1                 grant from shared slave
//  rsp_valid_i  in   1                 response valid from slave
//  rsp_data_i   in   RspWidth          response payload from slave
//  rsp_ready_o  out  1                 response ready to slave
//  rsp_valid_o  out  NumIn             per-port response valid, onehot0
//  rsp_data_o   out  RspWidth          response payload, shared by all ports
//  rsp_ready_i  in   NumIn             per-port response ready
//  outst_o      out  $clog2(MaxOutstanding+1)  requests in flight
//  err_o        out  1                 1-cycle pulse: response with nothing in flight
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-high.
//  - Reset/flush values: FIFO empty, outst_o=0, err_o=0.
//    Every output then follows the combinational rules below with the FIFO empty.
//  - IdxWidth = max(1,$clog2(NumIn)). For NumIn==1, slv_idx_i is ignored and index 0 is stored.
//  - full = (outst_q==MaxOutstanding); empty = (outst_q==0). Both come from registers only.
//  - Request path, zero latency:
//    - mst_req_o = slv_req_i & ~full.
//    - slv_gnt_o = slv_req_i & mst_gnt_i & ~full.
//    - push = slv_gnt_o; the FIFO writes slv_idx_i at the tail.
//    - When full, requests stall even if a pop happens in the same cycle. There is no full bypass.
//  - Response path, zero latency:
//    - head = FIFO head index.
//    - rsp_valid_o[head] = rsp_valid_i & ~empty; all other bits are 0.
//    - rsp_data_o = rsp_data_i, unconditionally.
//    - rsp_ready_o = empty | rsp_ready_i[head].
//    - pop = rsp_valid_i & ~empty & rsp_ready_i[head].
//  - No empty bypass: a response in the same cycle as the first push sees empty.
//    The slave must respond at least 1 cycle after its grant.
//  - Orphan response: rsp_valid_i & empty is consumed (rsp_ready_o=1) and dropped.
//    err_o=1 in the following cycle (registered). The FIFO is unchanged.
//  - Simultaneous push and pop (not full, not empty): outst unchanged; both pointers advance.
//  - Pointers wrap modulo MaxOutstanding (non-power-of-2 depth supported).
//    outst_q counts 0..MaxOutstanding and never wraps.
//  - flush_i has priority over push/pop in the same cycle.
//    In-flight responses after a flush count as orphans.
//  - Reset asserted mid-operation immediately empties the FIFO.
//    Outputs go to their reset values asynchronously.
//  - Assertions: $onehot0(rsp_valid_o); no push when full; no pop when empty; pushed idx < NumIn.
// STRUCTURE
//  - Package arb_rsp_pkg: function idx_width(n) returning max(1,$clog2(n)); no parameter-dependent types.
//  - Sub-module arb_id_fifo #(Depth, Width).
//    - Register-array FIFO with wrapping rd/wr pointers and a fill counter.
//    - Ports: push/pop/data in/head data out/full/empty/usage/flush.
//  - Top level: request gating, head-index demux of valid/ready, err_o register.
// TESTING
//  1. Reset with rst_i=1 mid-burst (outst=3) -> outst_o=0, rsp_valid_o=0, err_o=0 immediately; slv_gnt_o follows slv_req_i & mst_gnt_i.
//  2. Grants for idx 2,0,3, responses D0,D1,D2 at 1/cycle -> rsp_valid_o=4'b0100,4'b0001,4'b1000 in order; outst_o 3->0.
//  3. MaxOutstanding=8: 8 grants, no responses -> outst_o=8, mst_req_o=0, slv_gnt_o=0 while slv_req_i=1; one pop re-enables grant next cycle.
//  4. outst=2, push and pop in the same cycle, plus a head port with rsp_ready_i=0 for 3 cycles -> rsp_ready_o=0 and data held; outst stays 2 on simultaneous push/pop.
//  5. rsp_valid_i=1 with outst=0 -> rsp_ready_o=1, rsp_valid_o=0, err_o=1 exactly one cycle later; outst_o stays 0.
//  6. NumIn=1, MaxOutstanding=3: random grant/response traffic (10k cycles) against a scoreboard -> in-order delivery, pointer wrap, zero errors.

Source files
------------

// File: rtl/arb_rsp_pkg.sv
// Shared helpers for the arbiter response router.
package arb_rsp_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rsp_router_if.sv
// Request/response bus between arbiter, router and shared slave.
interface arb_rsp_router_if
    import arb_rsp_pkg::*;
#(
    parameter int NumIn          = 4,
    parameter int RspWidth       = 32,
    parameter int MaxOutstanding = 8
);
    localparam int IdxWidth   = idx_width(NumIn);
    localparam int OutstWidth = $clog2(MaxOutstanding + 1);

    logic                  flush_i;
    logic                  slv_req_i;
    logic [IdxWidth-1:0]   slv_idx_i;
    logic                  slv_gnt_o;
    logic                  mst_req_o;
    logic                  mst_gnt_i;
    logic                  rsp_valid_i;
    logic [RspWidth-1:0]   rsp_data_i;
    logic                  rsp_ready_o;
    logic [NumIn-1:0]      rsp_valid_o;
    logic [RspWidth-1:0]   rsp_data_o;
    logic [NumIn-1:0]      rsp_ready_i;
    logic [OutstWidth-1:0] outst_o;
    logic                  err_o;

    modport slave (
        input  flush_i, slv_req_i, slv_idx_i, mst_gnt_i,
               rsp_valid_i, rsp_data_i, rsp_ready_i,
        output slv_gnt_o, mst_req_o, rsp_ready_o, rsp_valid_o,
               rsp_data_o, outst_o, err_o
    );

    modport master (
        output flush_i, slv_req_i, slv_idx_i, mst_gnt_i,
               rsp_valid_i, rsp_data_i, rsp_ready_i,
        input  slv_gnt_o, mst_req_o, rsp_ready_o, rsp_valid_o,
               rsp_data_o, outst_o, err_o
    );

endinterface

// File: rtl/arb_id_fifo.sv
// In-order FIFO of winning input indices; wrapping pointers support any depth.
module arb_id_fifo #(
    parameter int Depth = 8,
    parameter int Width = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           data_i,
    output logic [Width-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] usage_o
);
    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [Width-1:0]    mem_d [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                push_ok, pop_ok;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                cnt_d = cnt_q + CntWidth'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_d = cnt_q - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/arb_rsp_router.sv
// Records arbitration winners in order and steers slave responses back to them.
module arb_rsp_router
    import arb_rsp_pkg::*;
#(
    parameter int NumIn          = 4,
    parameter int RspWidth       = 32,
    parameter int MaxOutstanding = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    arb_rsp_router_if.slave  bus
);
    localparam int IdxWidth   = idx_width(NumIn);
    localparam int OutstWidth = $clog2(MaxOutstanding + 1);

    logic                  full, empty;
    logic                  push, pop;
    logic                  head_ready;
    logic [IdxWidth-1:0]   push_idx, head;
    logic [NumIn-1:0]      rsp_valid;
    logic [OutstWidth-1:0] usage;
    logic                  err_q, err_d;

    // No full bypass: a same-cycle pop never frees a slot for the request.
    assign bus.mst_req_o = bus.slv_req_i & ~full;
    assign push          = bus.slv_req_i & bus.mst_gnt_i & ~full;
    assign bus.slv_gnt_o = push;
    assign push_idx      = (NumIn == 1) ? '0 : bus.slv_idx_i;

    arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxWidth)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_idx),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (usage)
    );

    always_comb begin
        rsp_valid  = '0;
        head_ready = 1'b0;
        for (int i = 0; i < NumIn; i++) begin
            if (head == IdxWidth'(i)) begin
                rsp_valid[i] = bus.rsp_valid_i & ~empty;
                head_ready   = bus.rsp_ready_i[i];
            end
        end
    end

    // Orphan responses are swallowed so the slave never stalls on them.
    assign pop             = bus.rsp_valid_i & ~empty & head_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_ready_o = empty | head_ready;
    assign bus.rsp_data_o  = bus.rsp_data_i;
    assign bus.outst_o     = usage;
    assign err_d           = ~bus.flush_i & bus.rsp_valid_i & empty;
    assign bus.err_o       = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    a_rsp_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.rsp_valid_o));

    if (NumIn > 1) begin : g_idx_chk
        a_idx_range: assert property (@(posedge clk_i) disable iff (rst_i)
            push |-> (int'(bus.slv_idx_i) < NumIn));
    end

endmodule

// File: tb/tb_arb_rsp_router.sv
// Randomized and directed checks of arb_rsp_router against a queue model.
module tb_arb_rsp_router;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arb_rsp_router_if #(.NumIn(4), .RspWidth(32), .MaxOutstanding(8)) bus_a ();
    arb_rsp_router_if #(.NumIn(1), .RspWidth(32), .MaxOutstanding(3)) bus_b ();

    arb_rsp_router #(.NumIn(4), .RspWidth(32), .MaxOutstanding(8)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (bus_a.slave));
    arb_rsp_router #(.NumIn(1), .RspWidth(32), .MaxOutstanding(3)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (bus_b.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int q_a[$];
    int q_b[$];
    bit err_a = 1'b0;
    bit err_b = 1'b0;
    int pops_b = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the FIFO is a queue of issuing ports, responses go to its front.
    task automatic model_cycle(
        input int inst, input int max_out, input bit r, input bit flush,
        input bit req, input int idx, input bit mgnt, input bit rv,
        input int ready, input longint data,
        input int g_mreq, input int g_gnt, input int g_rv, input int g_rr,
        input longint g_data, input int g_outst, input int g_err);
        int q[$];
        bit e, full, empty, gnt, pop;
        int head;
        string p;
        p = (inst == 0) ? "a" : "b";
        if (inst == 0) begin q = q_a; e = err_a; end
        else begin q = q_b; e = err_b; end
        if (r) begin q.delete(); e = 1'b0; end
        full  = (q.size() == max_out);
        empty = (q.size() == 0);
        head  = empty ? 0 : q[0];
        gnt   = req && mgnt && !full;
        pop   = rv && !empty && ((ready >> head) & 1) == 1;
        chk({p, ".mst_req"}, g_mreq, (req && !full) ? 1 : 0);
        chk({p, ".slv_gnt"}, g_gnt, gnt ? 1 : 0);
        chk({p, ".rsp_valid"}, g_rv, (rv && !empty) ? (1 << head) : 0);
        chk({p, ".rsp_ready"}, g_rr, (empty || ((ready >> head) & 1) == 1) ? 1 : 0);
        chk({p, ".rsp_data"}, g_data, data);
        chk({p, ".outst"}, g_outst, q.size());
        chk({p, ".err"}, g_err, e ? 1 : 0);
        if (!r) begin
            if (flush) begin
                q.delete();
                e = 1'b0;
            end else begin
                e = rv && empty;
                if (pop) begin
                    void'(q.pop_front());
                    if (inst == 1) pops_b++;
                end
                if (gnt) q.push_back(idx);
            end
        end
        if (inst == 0) begin q_a = q; err_a = e; end
        else begin q_b = q; err_b = e; end
    endtask

    always @(negedge clk) begin
        model_cycle(0, 8, rst, bus_a.flush_i, bus_a.slv_req_i, int'(bus_a.slv_idx_i),
                    bus_a.mst_gnt_i, bus_a.rsp_valid_i, int'(bus_a.rsp_ready_i),
                    longint'(bus_a.rsp_data_i),
                    int'(bus_a.mst_req_o), int'(bus_a.slv_gnt_o), int'(bus_a.rsp_valid_o),
                    int'(bus_a.rsp_ready_o), longint'(bus_a.rsp_data_o),
                    int'(bus_a.outst_o), int'(bus_a.err_o));
        model_cycle(1, 3, rst, bus_b.flush_i, bus_b.slv_req_i, 0,
                    bus_b.mst_gnt_i, bus_b.rsp_valid_i, int'(bus_b.rsp_ready_i),
                    longint'(bus_b.rsp_data_i),
                    int'(bus_b.mst_req_o), int'(bus_b.slv_gnt_o), int'(bus_b.rsp_valid_o),
                    int'(bus_b.rsp_ready_o), longint'(bus_b.rsp_data_o),
                    int'(bus_b.outst_o), int'(bus_b.err_o));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.flush_i     = 1'b0;
        bus_a.slv_req_i   = 1'b0;
        bus_a.slv_idx_i   = '0;
        bus_a.mst_gnt_i   = 1'b0;
        bus_a.rsp_valid_i = 1'b0;
        bus_a.rsp_data_i  = '0;
        bus_a.rsp_ready_i = '0;
    endtask

    task automatic idle_b();
        bus_b.flush_i     = 1'b0;
        bus_b.slv_req_i   = 1'b0;
        bus_b.slv_idx_i   = '0;
        bus_b.mst_gnt_i   = 1'b0;
        bus_b.rsp_valid_i = 1'b0;
        bus_b.rsp_data_i  = '0;
        bus_b.rsp_ready_i = '0;
    endtask

    task automatic push_a(input int idx);
        bus_a.slv_req_i = 1'b1;
        bus_a.mst_gnt_i = 1'b1;
        bus_a.slv_idx_i = 2'(idx);
        tick();
        bus_a.slv_req_i = 1'b0;
        bus_a.mst_gnt_i = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0100;
        exp_seq[1] = 4'b0001;
        exp_seq[2] = 4'b1000;
        idle_a();
        idle_b();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Three grants then three back-to-back responses
        push_a(2); push_a(0); push_a(3);
        #1 chk("t2.outst3", bus_a.outst_o, 3);
        bus_a.rsp_ready_i = 4'hF;
        bus_a.rsp_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_a.rsp_data_i = 32'hD000_0000 + 32'(i);
            #1 chk("t2.rsp_valid", bus_a.rsp_valid_o, exp_seq[i]);
            chk("t2.rsp_data", bus_a.rsp_data_o, 32'hD000_0000 + 32'(i));
            tick();
        end
        bus_a.rsp_valid_i = 1'b0;
        #1 chk("t2.outst0", bus_a.outst_o, 0);

        // Fill to capacity, verify stall and no full bypass
        for (int i = 0; i < 8; i++) push_a(i % 4);
        bus_a.slv_req_i = 1'b1;
        bus_a.mst_gnt_i = 1'b1;
        bus_a.slv_idx_i = 2'd1;
        #1 chk("t3.outst8", bus_a.outst_o, 8);
        chk("t3.mst_req_full", bus_a.mst_req_o, 0);
        chk("t3.gnt_full", bus_a.slv_gnt_o, 0);
        bus_a.rsp_valid_i = 1'b1;
        #1 chk("t3.gnt_no_bypass", bus_a.slv_gnt_o, 0);
        tick();
        bus_a.rsp_valid_i = 1'b0;
        #1 chk("t3.gnt_after_pop", bus_a.slv_gnt_o, 1);
        chk("t3.outst7", bus_a.outst_o, 7);
        tick();
        idle_a();
        bus_a.rsp_ready_i = 4'hF;
        bus_a.rsp_valid_i = 1'b1;
        repeat (8) tick();
        bus_a.rsp_valid_i = 1'b0;
        #1 chk("t3.drained", bus_a.outst_o, 0);

        // Simultaneous push/pop, then a stalled head port
        push_a(1); push_a(2);
        bus_a.slv_req_i   = 1'b1;
        bus_a.mst_gnt_i   = 1'b1;
        bus_a.slv_idx_i   = 2'd3;
        bus_a.rsp_valid_i = 1'b1;
        bus_a.rsp_ready_i = 4'b0010;
        #1 chk("t4.pp_valid", bus_a.rsp_valid_o, 4'b0010);
        chk("t4.pp_gnt", bus_a.slv_gnt_o, 1);
        tick();
        bus_a.slv_req_i   = 1'b0;
        bus_a.mst_gnt_i   = 1'b0;
        bus_a.rsp_ready_i = 4'b1011;
        bus_a.rsp_data_i  = 32'h5555_1234;
        #1 chk("t4.outst_pp", bus_a.outst_o, 2);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4.stall_ready", bus_a.rsp_ready_o, 0);
            chk("t4.stall_valid", bus_a.rsp_valid_o, 4'b0100);
            chk("t4.stall_data", bus_a.rsp_data_o, 32'h5555_1234);
            chk("t4.stall_outst", bus_a.outst_o, 2);
            tick();
        end
        bus_a.rsp_ready_i = 4'hF;
        repeat (2) tick();
        bus_a.rsp_valid_i = 1'b0;
        #1 chk("t4.drained", bus_a.outst_o, 0);

        // Orphan response
        bus_a.rsp_valid_i = 1'b1;
        bus_a.rsp_ready_i = 4'h0;
        #1 chk("t5.orphan_ready", bus_a.rsp_ready_o, 1);
        chk("t5.orphan_valid", bus_a.rsp_valid_o, 0);
        chk("t5.err_same", bus_a.err_o, 0);
        tick();
        bus_a.rsp_valid_i = 1'b0;
        #1 chk("t5.err_next", bus_a.err_o, 1);
        chk("t5.outst", bus_a.outst_o, 0);
        tick();
        #1 chk("t5.err_gone", bus_a.err_o, 0);

        // Async reset mid-burst
        push_a(0); push_a(1);
        bus_a.slv_req_i = 1'b1;
        bus_a.mst_gnt_i = 1'b1;
        bus_a.slv_idx_i = 2'd2;
        tick();
        #1 chk("t1.outst3", bus_a.outst_o, 3);
        bus_a.rsp_valid_i = 1'b1;
        bus_a.rsp_ready_i = 4'hF;
        rst = 1'b1;
        #1 chk("t1.rst_outst", bus_a.outst_o, 0);
        chk("t1.rst_valid", bus_a.rsp_valid_o, 0);
        chk("t1.rst_err", bus_a.err_o, 0);
        chk("t1.rst_gnt", bus_a.slv_gnt_o, 1);
        tick();
        idle_a();
        rst = 1'b0;
        tick();

        // Random traffic on the 4-port instance, with occasional flushes
        for (int c = 0; c < 3000; c++) begin
            bus_a.flush_i     = ($urandom_range(0, 63) == 0);
            bus_a.slv_req_i   = ($urandom_range(0, 3) != 0);
            bus_a.slv_idx_i   = 2'($urandom_range(0, 3));
            bus_a.mst_gnt_i   = 1'($urandom);
            bus_a.rsp_valid_i = ($urandom_range(0, 2) != 0);
            bus_a.rsp_data_i  = $urandom;
            bus_a.rsp_ready_i = 4'($urandom);
            tick();
        end
        idle_a();

        // Random traffic on the single-port, depth-3 instance
        for (int c = 0; c < 10000; c++) begin
            bus_b.slv_req_i   = 1'($urandom);
            bus_b.slv_idx_i   = 1'($urandom);
            bus_b.mst_gnt_i   = ($urandom_range(0, 3) != 0);
            bus_b.rsp_valid_i = ($urandom_range(0, 2) != 0);
            bus_b.rsp_data_i  = $urandom;
            bus_b.rsp_ready_i = 1'($urandom);
            tick();
        end
        idle_b();
        tick();
        n_tests++;
        if (pops_b < 100) begin
            n_fail++;
            $display("FAIL b.traffic: got %0d deliveries required at least 100", pops_b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
